dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller_if.sv | 26 ++
 rtl/dma_controller.sv | 108 ++++++++++
 tb/tb_dma_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_if.sv
// DMA controller bus bundle: CPU command/arbitration, device block port, memory burst port.
// Latency: none, wiring only.
// Backpressure: memory stalls through mem_ack, the CPU through bg; master is the DMA side.
interface dma_controller_if;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic        bg;
  logic [63:0] dev_data;
  logic        mem_ack;
  logic        br;
  logic [1:0]  offset;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic        done;

  modport master (
    input  cmd_valid, cmd_addr, bg, dev_data, mem_ack,
    output br, offset, mem_write, mem_addr, mem_data, done
  );

  modport slave (
    output cmd_valid, cmd_addr, bg, dev_data, mem_ack,
    input  br, offset, mem_write, mem_addr, mem_data, done
  );
endinterface

// File: rtl/dma_controller.sv
// DMA controller: moves three 4-word device blocks to base, base+4, base+8 (mod 2^16), then pulses done.
// Latency: cmd_valid to br 1 cycle; granted edge to mem_write 2 cycles; 3 bursts back-to-back.
// Backpressure: WRITE holds until mem_ack; losing bg aborts the burst and retries it. Macro DMA_CYCLE_STEAL_EN
//   drops br for one cycle between bursts and re-arbitrates each one.
module dma_controller (
  input  logic             clk,
  input  logic             reset,
  dma_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FETCH,
    S_WRITE,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [15:0] base;
  logic [63:0] data_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; an ack wins over a simultaneous grant loss.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (bus.cmd_valid) state_nxt = S_REQ;
      S_REQ:     if (bus.bg) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = bus.bg ? S_WRITE : S_REQ;
      S_WRITE: begin
        if (bus.mem_ack) begin
          if (idx == 2'd2) begin
            state_nxt = S_DONE;
          end else begin
`ifdef DMA_CYCLE_STEAL_EN
            state_nxt = S_RELEASE;
`else
            state_nxt = S_FETCH;
`endif
          end
        end else if (!bus.bg) begin
          state_nxt = S_REQ;
        end
      end
      S_RELEASE: state_nxt = S_REQ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Transfer context: base latched on command, block captured leaving FETCH, idx advanced on ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= 2'd0;
      base   <= 16'd0;
      data_q <= 64'd0;
    end else begin
      if (state == S_IDLE && bus.cmd_valid) begin
        base <= bus.cmd_addr;
        idx  <= 2'd0;
      end
      if (state == S_FETCH && bus.bg) begin
        data_q <= bus.dev_data;
      end
      if (state == S_WRITE && bus.mem_ack && idx != 2'd2) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Moore outputs decoded from state; idle values keep the device and memory ports quiet.
  always_comb begin
    bus.br        = 1'b0;
    bus.offset    = 2'b11;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 16'd0;
    bus.done      = 1'b0;
    unique case (state)
      S_REQ:   bus.br = 1'b1;
      S_FETCH: begin
        bus.br     = 1'b1;
        bus.offset = idx;
      end
      S_WRITE: begin
        bus.br        = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = base + {12'd0, idx, 2'b00};
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_data = data_q;

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: vector table of transfers, scoreboard of expected memory writes,
// plus grant-loss, reset-abort and busy-command sequences.
module tb_dma_controller;

  logic clk = 1'b0;
  logic reset;

  dma_controller_if bus ();

  dma_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          ack_dly;
    int          drop_burst;
    bit          busy;
    bit          rst_mid;
    logic [15:0] ea0;
    logic [15:0] ea1;
    logic [15:0] ea2;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q [$];
  wr_t         sb_e;
  logic [63:0] blk [0:3];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_v = -1;
  int          ack_dly = 1;
  int          drop_burst = -1;
  int          nb;
  int          wcnt;
  int          dropcnt;
  bit          dropped;
  vec_t        vecs [7];

  // Device model: block per offset, quiet when idle.
  assign bus.dev_data = (bus.offset == 2'b11) ? 64'h0 : blk[bus.offset];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, cur_v, act, exp);
    end
  endtask

  // Memory/CPU responder: acks after ack_dly cycles, optionally withdraws bg for 3 cycles in one WRITE.
  always @(negedge clk) begin
    if (reset) begin
      bus.mem_ack = 1'b0;
      bus.bg      = 1'b1;
      wcnt        = 0;
      dropcnt     = 0;
      nb          = 0;
      dropped     = 1'b0;
      exp_q.delete();
    end else if (dropcnt > 0) begin
      bus.mem_ack = 1'b0;
      chk("grant_loss_br", bus.br, 1);
      chk("grant_loss_wr", bus.mem_write, 0);
      dropcnt--;
      if (dropcnt == 0) bus.bg = 1'b1;
    end else if (bus.mem_write) begin
      if (nb == drop_burst && !dropped && wcnt == 0) begin
        bus.bg      = 1'b0;
        bus.mem_ack = 1'b0;
        dropcnt     = 3;
        dropped     = 1'b1;
      end else if (wcnt == ack_dly) begin
        bus.mem_ack = 1'b1;
        wcnt        = 0;
        nb++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected (vec %0d): got write at %0h, expected none", cur_v, bus.mem_addr);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_addr", bus.mem_addr, sb_e.addr);
          chk("sb_data", bus.mem_data, sb_e.data);
        end
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt        = 0;
      if (bus.done) begin
        nb      = 0;
        dropped = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_br"}, bus.br, 0);
    chk({tag, "_offset"}, bus.offset, 2'b11);
    chk({tag, "_mem_write"}, bus.mem_write, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_data"}, bus.mem_data, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] ea [0:2];
    wr_t         w;
    int          ndone;
    int          brlow;
    int          exp_brlow;
    bit          found;
    ea[0] = v.ea0;
    ea[1] = v.ea1;
    ea[2] = v.ea2;
`ifdef DMA_CYCLE_STEAL_EN
    exp_brlow = 2;
`else
    exp_brlow = 0;
`endif
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      blk[i] = {$urandom, $urandom};
      w.addr = ea[i];
      w.data = blk[i];
      exp_q.push_back(w);
    end
    ack_dly       = v.ack_dly;
    drop_burst    = v.drop_burst;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 16'($urandom);
    chk("req_br", bus.br, 1);
    chk("req_offset", bus.offset, 2'b11);
    chk("req_mem_write", bus.mem_write, 0);
    @(negedge clk);
    chk("fetch_br", bus.br, 1);
    chk("fetch_offset", bus.offset, 0);
    @(negedge clk);
    chk("write_vld", bus.mem_write, 1);
    chk("write_addr0", bus.mem_addr, ea[0]);

    if (v.rst_mid) begin
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clk);
        if (bus.mem_write && bus.mem_addr == ea[1]) found = 1'b1;
      end
      chk("rst_reached_burst1", found, 1);
      reset = 1'b1;
      #1;
      chk_reset_outputs("rst_mid");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      brlow = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (bus.done) ndone++;
        if (bus.br) brlow++;
      end
      chk("rst_no_done", ndone, 0);
      chk("rst_stays_idle", brlow, 0);
      return;
    end

    ndone = 0;
    brlow = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (v.busy && i == 3) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 16'h0100;
      end else if (v.busy && i == 4) begin
        bus.cmd_valid = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        chk("done_br", bus.br, 0);
        break;
      end else if (!bus.br) begin
        brlow++;
      end
    end
    chk("done_seen", ndone, 1);
    chk("br_low_cycles", brlow, exp_brlow);
    chk("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("post_done", bus.done, 0);
    chk("post_br", bus.br, 0);
    chk("post_offset", bus.offset, 2'b11);
    chk("post_mem_addr", bus.mem_addr, 0);
  endtask

  initial begin
    //          addr      dly drop busy rst  ea0       ea1       ea2
    vecs[0] = '{16'h01F4, 1, -1, 1'b0, 1'b0, 16'h01F4, 16'h01F8, 16'h01FC};
    vecs[1] = '{16'hFFFC, 1, -1, 1'b0, 1'b0, 16'hFFFC, 16'h0000, 16'h0004};
    vecs[2] = '{16'h01F4, 1,  1, 1'b0, 1'b0, 16'h01F4, 16'h01F8, 16'h01FC};
    vecs[3] = '{16'h01F4, 4, -1, 1'b0, 1'b1, 16'h01F4, 16'h01F8, 16'h01FC};
    vecs[4] = '{16'h0800, 1, -1, 1'b0, 1'b0, 16'h0800, 16'h0804, 16'h0808};
    vecs[5] = '{16'h2000, 4, -1, 1'b0, 1'b0, 16'h2000, 16'h2004, 16'h2008};
    vecs[6] = '{16'h0040, 2, -1, 1'b1, 1'b0, 16'h0040, 16'h0044, 16'h0048};

    for (int i = 0; i < 4; i++) blk[i] = 64'h0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      cur_v = v;
      run_vec(vecs[v]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
